// File: rtl/sign_extend.sv
// Registered 16->32 immediate extension (sign/zero/upper/sign-shl2) with a valid flag.
// Define SIGN_EXTEND_COMB_EN to bypass the output registers (zero-latency combinational build).
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  instruction,
    output logic             out_valid,
    output logic [OUT_W-1:0] q
);

    typedef enum logic [1:0] {
        MODE_SEXT     = 2'b00,
        MODE_ZEXT     = 2'b01,
        MODE_UPPER    = 2'b10,
        MODE_SEXT_SL2 = 2'b11
    } mode_e;

    generate
        if (OUT_W < 2 * IN_W) begin : g_bad_width
            $error("sign_extend: OUT_W must be at least 2*IN_W");
        end
    endgenerate

    // Fill and shift bits are constant zeros so they never pick up X from the input.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [1:0] m,
                                                    input logic [IN_W-1:0] imm);
        logic signed [OUT_W-1:0] sext;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (m)
            MODE_SEXT:  extend_imm = sext;
            MODE_ZEXT:  extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_UPPER: extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
            default:    extend_imm = sext << 2;
        endcase
    endfunction

    logic [OUT_W-1:0] res_d;
    assign res_d = extend_imm(mode, instruction);

`ifdef SIGN_EXTEND_COMB_EN
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    assign q         = res_d;
    assign out_valid = in_valid;
`else
    logic [OUT_W-1:0] res_q;
    logic             vld_q;

    // Output stage: result only updates on accepted inputs; valid is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign q         = res_q;
    assign out_valid = vld_q;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: reset, vector table, hold/mid-run reset, random vs. model.
module tb_sign_extend;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] instruction = 16'h0000;
    logic        out_valid;
    logic [31:0] q;

    int n_checks = 0;
    int n_errors = 0;

    sign_extend #(.IN_W(16), .OUT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .mode       (mode),
        .instruction(instruction),
        .out_valid  (out_valid),
        .q          (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] ins;
        logic [31:0] exp;
    } vec_t;

    // Reference: treat the immediate as an integer and apply the mode arithmetically.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] ins);
        longint u;
        longint s;
        u = longint'(ins);
        s = (u >= 32768) ? u - 65536 : u;
        case (m)
            2'd0:    return 32'(s);
            2'd1:    return 32'(u);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [1:0] m, input logic [15:0] ins);
        @(negedge clk);
        in_valid    = v;
        mode        = m;
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] exp_q;
        logic        exp_v;

        vecs[0] = '{2'b00, 16'h03E0, 32'h000003E0};
        vecs[1] = '{2'b00, 16'hFC1F, 32'hFFFFFC1F};
        vecs[2] = '{2'b01, 16'hFC1F, 32'h0000FC1F};
        vecs[3] = '{2'b10, 16'hFC1F, 32'hFC1F0000};
        vecs[4] = '{2'b10, 16'h03E0, 32'h03E00000};
        vecs[5] = '{2'b11, 16'hFC1F, 32'hFFFFF07C};
        vecs[6] = '{2'b11, 16'h03E0, 32'h00000F80};
        vecs[7] = '{2'b11, 16'h8000, 32'hFFFE0000};
        vecs[8] = '{2'b01, 16'hFFFF, 32'h0000FFFF};

`ifdef SIGN_EXTEND_COMB_EN
        in_valid = 1'b1; mode = 2'b00; instruction = 16'h8001;
        #1;
        chk("comb_sext_q", q, 32'hFFFF8001);
        chk("comb_vld_hi", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #1;
        chk("comb_vld_lo", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; mode = vecs[i].mode; instruction = vecs[i].ins;
            #1;
            chk("comb_table", q, vecs[i].exp);
        end
`else
        // Reset held with active inputs: outputs must stay zero.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 16'hFFFF);
            chk("reset_q", q, 32'h0);
            chk("reset_vld", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("release_q", q, 32'h0);
        chk("release_vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("first_cap_q", q, 32'hFFFFFFFF);
        chk("first_cap_vld", {31'd0, out_valid}, 32'd1);

        // Back-to-back vector table.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i].mode, vecs[i].ins);
            chk($sformatf("table%0d_q", i), q, vecs[i].exp);
            chk($sformatf("table%0d_vld", i), {31'd0, out_valid}, 32'd1);
        end

        // Hold when in_valid drops.
        step(1'b1, 2'b00, 16'h7FFF);
        chk("hold_cap_q", q, 32'h00007FFF);
        step(1'b0, 2'b10, 16'h1234);
        chk("hold_q", q, 32'h00007FFF);
        chk("hold_vld", {31'd0, out_valid}, 32'd0);

        // Mid-cycle reset pulse clears immediately; the in-flight input is lost.
        step(1'b1, 2'b01, 16'hABCD);
        chk("pre_rst_q", q, 32'h0000ABCD);
        @(negedge clk);
        in_valid = 1'b1; mode = 2'b00; instruction = 16'h5555;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_q", q, 32'h0);
        chk("midrst_vld", {31'd0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_q", q, 32'h0);
        chk("post_rst_vld", {31'd0, out_valid}, 32'd0);

        // Random traffic against the arithmetic model.
        exp_q = 32'h0;
        for (int i = 0; i < 300; i++) begin
            logic        v;
            logic [1:0]  m;
            logic [15:0] ins;
            v   = ($urandom_range(0, 3) != 0);
            m   = 2'($urandom_range(0, 3));
            ins = 16'($urandom);
            step(v, m, ins);
            if (v) exp_q = model(m, ins);
            exp_v = v;
            chk("rand_q", q, exp_q);
            chk("rand_vld", {31'd0, out_valid}, {31'd0, exp_v});
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sign_extend.md
Name: sign_extend

Overview:
- Registered immediate-extension unit for the datapath's decode/execute boundary.
- Widens a 16-bit instruction immediate field to a 32-bit operand.
- Four extension modes: sign, zero, upper (LUI-style) and sign-with-word-shift (branch offset).
- Result is captured on the clock edge and qualified by a valid flag, so it feeds the ALU/branch adder directly.

Parameters:
- IN_W, 16, width of the immediate input.
- OUT_W, 32, width of the extended output. Must satisfy OUT_W >= 2*IN_W.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction/mode sampled this cycle when high.
- mode  input  2  extension mode select (encoding below).
- instruction  input  IN_W  immediate field; bit IN_W-1 is the sign bit.
- out_valid  output  1  q holds a freshly computed result.
- q  output  OUT_W  extended immediate.

Behaviour:
- Reset:
  - rst_n low forces q=0 and out_valid=0 immediately, with no clock needed.
  - Both outputs stay 0 while rst_n is low.
  - First capture occurs on the first rising clk edge with rst_n high and in_valid high.
- Mode encoding (s = instruction[IN_W-1]):
  - 00 SEXT: q = {(OUT_W-IN_W){s}, instruction}.
  - 01 ZEXT: q = {(OUT_W-IN_W){0}, instruction}.
  - 10 UPPER: q = instruction placed in q[OUT_W-1:OUT_W-IN_W], all lower bits 0.
  - 11 SEXT_SL2: q = (SEXT result) << 2, truncated to OUT_W. The two LSBs are 0; the bits shifted out of the top are discarded.
- Latency: exactly 1 clk. On a rising edge with in_valid=1, q takes the mode result and out_valid goes to 1.
- Hold: on a rising edge with in_valid=0, q holds its previous value and out_valid goes to 0.
- No backpressure: a new input is accepted every cycle; back-to-back valid inputs give back-to-back results.
- Unknown or X bits on instruction are not sanitized. The shift and zero-fill bits are always driven 0, never X.
- Reset asserted mid-stream discards any in-flight result. After release, outputs stay 0 until the next valid capture.
- Purely combinational next-state logic; no internal state other than the q and out_valid registers.

Optional Feature:
- SIGN_EXTEND_COMB_EN defined:
  - Output registers are bypassed.
  - q is the combinational mode result of the current instruction and mode.
  - out_valid = in_valid, with zero latency.
  - clk and rst_n are unused.
- SIGN_EXTEND_COMB_EN not defined: registered 1-cycle behaviour as specified above.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and instruction=0xFFFF over several edges -> q=0x00000000 and out_valid=0 throughout. Deassert asynchronously between edges -> outputs remain 0 until the next edge.
- SEXT: mode=00, instruction=0x03E0, then next cycle 0xFC1F -> q=0x000003E0, then q=0xFFFFFC1F on consecutive cycles, out_valid=1 both cycles.
- ZEXT/UPPER: mode=01 with 0xFC1F -> 0x0000FC1F. mode=10 with 0xFC1F -> 0xFC1F0000. mode=10 with 0x03E0 -> 0x03E00000.
- SEXT_SL2: mode=11 with 0xFC1F -> 0xFFFFF07C. mode=11 with 0x03E0 -> 0x00000F80. mode=11 with 0x8000 -> 0xFFFE0000.
- Hold and mid-run reset:
  - Capture 0x7FFF in SEXT (q=0x00007FFF), then drop in_valid and change instruction -> q stays 0x00007FFF, out_valid=0.
  - Pulse rst_n low mid-cycle -> q=0 immediately.
- Macro build with SIGN_EXTEND_COMB_EN: mode=00, instruction=0x8001 -> q=0xFFFF8001 in the same delta, out_valid follows in_valid with no clock.
